// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg - shared encodings for the multicycle CPU control path and datapath.
//   Opcode constants, FSM state encodings, PCSrc / RegDst / ALUOp mux
//   encodings, and small opcode classification helpers.
// Optional feature: define JAL_EN to decode jal/jr; otherwise they are
//   treated as undecoded opcodes (NOP).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int OP_W = 6;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // FSM states
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    // PCSrc mux
    localparam logic [1:0] PC_SEQ = 2'b00;  // PC+4
    localparam logic [1:0] PC_BR  = 2'b01;  // branch target
    localparam logic [1:0] PC_REG = 2'b10;  // register (jr)
    localparam logic [1:0] PC_JMP = 2'b11;  // jump target (j/jal)

    // RegDst mux
    localparam logic [1:0] RD_RA = 2'b00;   // $31
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    // ALUOp
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    typedef enum logic [2:0] {
        C_ALU, C_LS, C_BR, C_JMP, C_HALT, C_NONE
    } op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND,
            OP_ANDI, OP_ORI, OP_SLT:           return C_ALU;
            OP_SW, OP_LW:                      return C_LS;
            OP_BEQ, OP_BNE:                    return C_BR;
            OP_J:                              return C_JMP;
`ifdef JAL_EN
            OP_JAL, OP_JR:                     return C_JMP;
`endif
            OP_HALT:                           return C_HALT;
            default:                           return C_NONE;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
            OP_AND, OP_ANDI:        return ALU_AND;
            OP_ORI:                 return ALU_OR;
            OP_SLT:                 return ALU_SLT;
            default:                return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode - combinational control-signal decode from (state, op, zero).
//   Inputs : op_i (opcode), state_i (current FSM state), zero_i (ALU zero)
//   Outputs: write/read enables, datapath mux selects, ALU function.
// Optional feature: JAL_EN enables jal/jr decode.
// ---------------------------------------------------------------------------
module control_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] op_i,
    input  logic [2:0]     state_i,
    input  logic           zero_i,
    output logic           pc_wre_o,
    output logic           ir_wre_o,
    output logic           reg_wre_o,
    output logic           mrd_o,
    output logic           mwr_o,
    output logic           alu_src_a_o,
    output logic           alu_src_b_o,
    output logic           db_data_src_o,
    output logic           wr_reg_d_src_o,
    output logic           ext_sel_o,
    output logic [1:0]     reg_dst_o,
    output logic [1:0]     pc_src_o,
    output logic [2:0]     alu_op_o
);

    logic [OP_W-1:0] opc;
    state_e          st;
    op_class_e       cls;
    logic            is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
    logic            is_imm;   // ALU ops writing rt from an immediate
    logic            is_zext;  // logical immediates zero-extend

    assign opc     = OP_W'(op_i);
    assign st      = state_e'(state_i);
    assign cls     = op_class(opc);
    assign is_lw   = (opc == OP_LW);
    assign is_sw   = (opc == OP_SW);
    assign is_beq  = (opc == OP_BEQ);
    assign is_bne  = (opc == OP_BNE);
    assign is_j    = (opc == OP_J);
    assign is_zext = (opc == OP_ANDI) || (opc == OP_ORI);
    assign is_imm  = is_zext || (opc == OP_ADDIU);
`ifdef JAL_EN
    assign is_jal  = (opc == OP_JAL);
    assign is_jr   = (opc == OP_JR);
`else
    assign is_jal  = 1'b0;
    assign is_jr   = 1'b0;
`endif

    always_comb begin
        pc_wre_o       = 1'b0;
        ir_wre_o       = 1'b0;
        reg_wre_o      = 1'b0;
        mrd_o          = 1'b0;
        mwr_o          = 1'b0;
        // No shift instructions in this ISA subset, so port A is always rs.
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = is_imm || is_lw || is_sw;
        db_data_src_o  = is_lw;
        wr_reg_d_src_o = !is_jal;
        ext_sel_o      = !is_zext;
        reg_dst_o      = RD_RT;
        pc_src_o       = PC_SEQ;
        alu_op_o       = ALU_ADD;

        case (st)
            S_IF: ir_wre_o = 1'b1;
            S_ID: begin
                // Jumps, undecoded ops finish here; halt never advances PC.
                pc_wre_o = (cls == C_JMP) || (cls == C_NONE);
                if (is_jal) begin
                    reg_wre_o = 1'b1;
                    reg_dst_o = RD_RA;
                end
                if (is_j || is_jal) pc_src_o = PC_JMP;
                else if (is_jr)     pc_src_o = PC_REG;
            end
            S_EXE_AL: alu_op_o = alu_fn(opc);
            S_WB_AL: begin
                alu_op_o  = alu_fn(opc);
                pc_wre_o  = 1'b1;
                reg_wre_o = 1'b1;
                reg_dst_o = is_imm ? RD_RT : RD_RD;
            end
            S_EXE_BR: begin
                alu_op_o = alu_fn(opc);
                pc_wre_o = 1'b1;
                if ((is_beq && zero_i) || (is_bne && !zero_i)) pc_src_o = PC_BR;
            end
            S_EXE_LS: alu_op_o = alu_fn(opc);
            S_MEM: begin
                alu_op_o = alu_fn(opc);
                mrd_o    = is_lw;
                mwr_o    = is_sw;
                pc_wre_o = is_sw;
            end
            S_WB_LD: begin
                pc_wre_o  = 1'b1;
                reg_wre_o = 1'b1;
                reg_dst_o = RD_RT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm - multicycle CPU control unit (state register + next state).
//   CLK, Reset (async, active low), op (opcode), zero (ALU zero flag)
//   PCWre, IRWre, RegWre, mRD, mWR           : enables
//   ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc,
//   ExtSel, RegDst, PCSrc, ALUOp             : datapath selects
//   state                                    : current state (debug)
// Optional feature: define JAL_EN to decode jal/jr.
// ---------------------------------------------------------------------------
module control_fsm
    import cpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           RegWre,
    output logic           mRD,
    output logic           mWR,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           DBDataSrc,
    output logic           WrRegDSrc,
    output logic           ExtSel,
    output logic [1:0]     RegDst,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUOp,
    output logic [2:0]     state
);

    state_e    state_q, state_d;
    op_class_e cls;
    logic      pc_wre, reg_wre, mrd, mwr;

    assign cls = op_class(OP_W'(op));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (cls)
                    C_ALU:   state_d = S_EXE_AL;
                    C_LS:    state_d = S_EXE_LS;
                    C_BR:    state_d = S_EXE_BR;
                    default: state_d = S_IF;
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (OP_W'(op) == OP_LW) ? S_WB_LD : S_IF;
            default:  state_d = S_IF;
        endcase
    end

    control_decode #(.OPW(OPW)) u_dec (
        .op_i           (op),
        .state_i        (state_q),
        .zero_i         (zero),
        .pc_wre_o       (pc_wre),
        .ir_wre_o       (IRWre),
        .reg_wre_o      (reg_wre),
        .mrd_o          (mrd),
        .mwr_o          (mwr),
        .alu_src_a_o    (ALUSrcA),
        .alu_src_b_o    (ALUSrcB),
        .db_data_src_o  (DBDataSrc),
        .wr_reg_d_src_o (WrRegDSrc),
        .ext_sel_o      (ExtSel),
        .reg_dst_o      (RegDst),
        .pc_src_o       (PCSrc),
        .alu_op_o       (ALUOp)
    );

    // State-changing strobes are held off for the whole reset window, not
    // just after the state register has been cleared.
    assign PCWre  = pc_wre  && Reset;
    assign RegWre = reg_wre && Reset;
    assign mRD    = mrd     && Reset;
    assign mWR    = mwr     && Reset;
    assign state  = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_fsm - scoreboard bench for control_fsm. Expected per-cycle
// control words are queued as each instruction is launched and compared at
// every falling edge. Build with or without JAL_EN.
// ---------------------------------------------------------------------------
module tb_control_fsm;

    logic       CLK, Reset, zero;
    logic [5:0] op;
    logic       PCWre, IRWre, RegWre, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp, state;

    control_fsm #(.OPW(6)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel), .RegDst(RegDst),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] st;
        logic       pcw, irw, rw, mrd, mwr;
        logic [1:0] rdst, pcs;
        logic [2:0] aop;
        logic       asb, ext, dbs, wrs;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic c_asb, c_ext, c_dbs, c_wrs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-instruction (state-independent) selects
    task automatic sel(input logic asb, input logic ext, input logic dbs, input logic wrs);
        c_asb = asb; c_ext = ext; c_dbs = dbs; c_wrs = wrs;
    endtask

    task automatic e(input logic [2:0] st, input logic pcw, input logic rw,
                     input logic mrd, input logic mwr, input logic [1:0] rdst,
                     input logic [1:0] pcs, input logic [2:0] aop);
        exp_t x;
        x.st = st; x.pcw = pcw; x.irw = (st == 3'b000); x.rw = rw;
        x.mrd = mrd; x.mwr = mwr; x.rdst = rdst; x.pcs = pcs; x.aop = aop;
        x.asb = c_asb; x.ext = c_ext; x.dbs = c_dbs; x.wrs = c_wrs;
        sb.push_back(x);
    endtask

    task automatic check_cycle(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            chk({tag, " sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        chk({tag, " state"},     state,     x.st);
        chk({tag, " PCWre"},     PCWre,     x.pcw);
        chk({tag, " IRWre"},     IRWre,     x.irw);
        chk({tag, " RegWre"},    RegWre,    x.rw);
        chk({tag, " mRD"},       mRD,       x.mrd);
        chk({tag, " mWR"},       mWR,       x.mwr);
        chk({tag, " RegDst"},    RegDst,    x.rdst);
        chk({tag, " PCSrc"},     PCSrc,     x.pcs);
        chk({tag, " ALUOp"},     ALUOp,     x.aop);
        chk({tag, " ALUSrcB"},   ALUSrcB,   x.asb);
        chk({tag, " ExtSel"},    ExtSel,    x.ext);
        chk({tag, " DBDataSrc"}, DBDataSrc, x.dbs);
        chk({tag, " WrRegDSrc"}, WrRegDSrc, x.wrs);
        chk({tag, " ALUSrcA"},   ALUSrcA,   1'b0);
        chk({tag, " rd_wr_excl"}, mRD & mWR, 1'b0);
    endtask

    // Called at a falling edge with the FSM in sIF; returns at a falling edge.
    task automatic run(input string tag, input logic [5:0] o, input logic z, input int n);
        op = o; zero = z;
        for (int i = 0; i < n; i++) begin
            #1;
            check_cycle($sformatf("%s c%0d", tag, i));
            @(negedge CLK);
        end
    endtask

    // ALU-class instruction: IF, ID, EXE_AL, WB_AL
    task automatic alu_instr(input string tag, input logic [5:0] o, input logic [2:0] aop,
                             input logic [1:0] rdst, input logic asb, input logic ext);
        sel(asb, ext, 1'b0, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b110, 0, 0, 0, 0, 2'b01, 2'b00, aop);
        e(3'b111, 1, 1, 0, 0, rdst,  2'b00, aop);
        run(tag, o, 1'b0, 4);
    endtask

    task automatic br_instr(input string tag, input logic [5:0] o, input logic z,
                            input logic [1:0] pcs);
        sel(1'b0, 1'b1, 1'b0, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b101, 1, 0, 0, 0, 2'b01, pcs,   3'b001);
        run(tag, o, z, 3);
    endtask

    initial begin
        Reset = 1'b0; op = 6'b111111; zero = 1'b0;
        c_asb = 0; c_ext = 1; c_dbs = 0; c_wrs = 1;

        // Reset held: strobes quiet regardless of op
        repeat (2) @(negedge CLK);
        #1;
        chk("rst state",  state,  3'b000);
        chk("rst PCWre",  PCWre,  1'b0);
        chk("rst RegWre", RegWre, 1'b0);
        op = 6'b110001;
        #1;
        chk("rst mRD", mRD, 1'b0);
        chk("rst mWR", mWR, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;

        alu_instr("add",   6'b000000, 3'b000, 2'b10, 1'b0, 1'b1);
        alu_instr("sub",   6'b000001, 3'b001, 2'b10, 1'b0, 1'b1);
        alu_instr("addiu", 6'b000010, 3'b000, 2'b01, 1'b1, 1'b1);
        alu_instr("and",   6'b010000, 3'b100, 2'b10, 1'b0, 1'b1);
        alu_instr("andi",  6'b010001, 3'b100, 2'b01, 1'b1, 1'b0);
        alu_instr("ori",   6'b010010, 3'b011, 2'b01, 1'b1, 1'b0);
        alu_instr("slt",   6'b100111, 3'b010, 2'b10, 1'b0, 1'b1);

        // lw: 5 cycles
        sel(1'b1, 1'b1, 1'b1, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b010, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b011, 0, 0, 1, 0, 2'b01, 2'b00, 3'b000);
        e(3'b100, 1, 1, 0, 0, 2'b01, 2'b00, 3'b000);
        run("lw", 6'b110001, 1'b0, 5);

        // sw: 4 cycles
        sel(1'b1, 1'b1, 1'b0, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b010, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b011, 1, 0, 0, 1, 2'b01, 2'b00, 3'b000);
        run("sw", 6'b110000, 1'b0, 4);

        br_instr("beq_z1", 6'b110100, 1'b1, 2'b01);
        br_instr("beq_z0", 6'b110100, 1'b0, 2'b00);
        br_instr("bne_z0", 6'b110101, 1'b0, 2'b01);
        br_instr("bne_z1", 6'b110101, 1'b1, 2'b00);

        // j: 2 cycles
        sel(1'b0, 1'b1, 1'b0, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 1, 0, 0, 0, 2'b01, 2'b11, 3'b000);
        run("j", 6'b111000, 1'b0, 2);

        // halt: refetches itself, PC never written
        for (int k = 0; k < 3; k++) begin
            e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
            e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        end
        run("halt", 6'b111111, 1'b0, 6);

        // undecoded opcode behaves as NOP
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 1, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        run("undef", 6'b101010, 1'b0, 2);

`ifdef JAL_EN
        sel(1'b0, 1'b1, 1'b0, 1'b0);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 1, 1, 0, 0, 2'b00, 2'b11, 3'b000);
        run("jal", 6'b111010, 1'b0, 2);
        sel(1'b0, 1'b1, 1'b0, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 1, 0, 0, 0, 2'b01, 2'b10, 3'b000);
        run("jr", 6'b111001, 1'b0, 2);
`else
        sel(1'b0, 1'b1, 1'b0, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 1, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        run("jal_nop", 6'b111010, 1'b0, 2);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 1, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        run("jr_nop", 6'b111001, 1'b0, 2);
`endif

        // Reset asserted in sMEM of lw
        sel(1'b1, 1'b1, 1'b1, 1'b1);
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b010, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        run("lw_pre", 6'b110001, 1'b0, 3);
        e(3'b011, 0, 0, 1, 0, 2'b01, 2'b00, 3'b000);
        #1;
        check_cycle("lw_mem");
        Reset = 1'b0;
        #1;
        chk("midrst state",  state,  3'b000);
        chk("midrst mRD",    mRD,    1'b0);
        chk("midrst RegWre", RegWre, 1'b0);
        chk("midrst PCWre",  PCWre,  1'b0);
        @(posedge CLK);
        #1;
        chk("midrst hold state",  state,  3'b000);
        chk("midrst hold RegWre", RegWre, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        e(3'b000, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        e(3'b001, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000);
        run("post_rst", 6'b110001, 1'b0, 2);

        chk("sb_left", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
